debounce_event_counter: RTL and testbench
=========================================

# debounce_event_counter

Parametrised multi-channel push-button front end: per-channel synchroniser, counter-based debouncer, edge detector and event counter, with a selectable readout port for the 7-segment display mux. It replaces the single-button debounce test path on the board top level. Each channel counts debounced edges of a selectable polarity, with wrap or saturate behaviour, per-channel clear and a sticky overflow flag.

## Interface
- N_CH, 4, number of button channels (1..16)
- CNT_W, 8, event counter width
- STABLE_CYCLES, 1000000, consecutive stable cycles required before the debounced level changes (≥2)
- EDGE_MODE, 0, 0 = count rising edges, 1 = falling, 2 = both
- SATURATE, 0, 0 = counter wraps, 1 = counter holds at all-ones
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- btn  in  N_CH  raw asynchronous button inputs
- clr  in  N_CH  per-channel synchronous clear of counter and overflow flag
- sel  in  max(1,$clog2(N_CH))  readout channel select
- cnt_out  out  CNT_W  registered count of the selected channel
- raw_cnt_out  out  CNT_W  registered raw-edge count of the selected channel (see Configuration)
- db_level  out  N_CH  debounced levels
- db_tick  out  N_CH  one-cycle pulse per counted edge
- ovf  out  N_CH  sticky overflow/saturation flags

## Operation
- Synchroniser: 2 flip-flops per channel; s = second stage.
- Debouncer FSM per channel: STABLE0, WAIT1, STABLE1, WAIT0; timer width $clog2(STABLE_CYCLES+1).
  - STABLE0: db_level=0; s=1 → WAIT1, timer=1.
  - WAIT1: s=0 → STABLE0; s=1 and timer==STABLE_CYCLES-1 → STABLE1; otherwise timer+1.
  - STABLE1 / WAIT0: mirror image, db_level=1 in both.
  - db_level is registered and equals 1 exactly in STABLE1 and WAIT0.
- Edge detection: db_d = db_level delayed one cycle. rise = db_level & ~db_d; fall = ~db_level & db_d. db_tick selects rise, fall or rise|fall according to EDGE_MODE.
- Counter update per channel, in priority order:
  - clr → count=0, ovf=0.
  - db_tick at count == all-ones → SATURATE=0: count=0 with ovf=1; SATURATE=1: count held with ovf=1.
  - db_tick → count+1.
  - Otherwise hold.
- Readout: cnt_out <= count[sel] each cycle. If sel ≥ N_CH, cnt_out <= 0.
- Reset: synchroniser stages, FSMs to STABLE0, timers, db_d, all counters, ovf, db_level, db_tick, cnt_out and raw_cnt_out all go to 0.

## Timing
- A clean btn step at edge E sets s high after edge E+2. db_level rises at edge E+1+STABLE_CYCLES+… and is exactly STABLE_CYCLES cycles after s first samples high.
- db_tick is high in the same cycle db_level first shows its new value. The count updates on the following edge. cnt_out reflects it one edge later.
- Input to db_tick latency is 2+STABLE_CYCLES cycles. db_tick to visible cnt_out change is 2 cycles.
- Any glitch shorter than STABLE_CYCLES cycles, as seen at s, produces no level change and no tick.
- sel to cnt_out latency is 1 cycle.
- clr takes effect on the next edge and wins over a simultaneous db_tick; that tick is lost.
- Reset mid-WAIT abandons the pending transition. A button held through reset is counted as a rising edge after STABLE_CYCLES cycles.

## Configuration
- DEBOUNCE_RAW_CNT_EN defined: each channel gains a second CNT_W counter. It increments on every rising edge of s, undebounced, always wraps, and is cleared by clr and reset. It is read through raw_cnt_out using the same sel and the same 1-cycle latency.
- Not defined: raw_cnt_out is a constant 0 and no raw counters are synthesised.

## Test plan
- Bench uses N_CH=4, CNT_W=8, STABLE_CYCLES=4, SATURATE=0, EDGE_MODE=0.
- Clean press on btn[2], held 20 cycles → db_tick[2] is a single pulse 6 cycles after the step; with sel=2, cnt_out=1 two cycles later. Other channels' counters stay at 0.
- Bounce on btn[0] (1,0,1,0 each 2 cycles, then steady 1) → exactly one tick. With DEBOUNCE_RAW_CNT_EN defined, raw_cnt_out=3 and cnt_out=1 for sel=0.
- 255 presses then 1 more on channel 1 → count 0xFF then 0x00 with ovf[1]=1. Rebuilt with SATURATE=1 → count stays 0xFF and ovf[1]=1.
- clr[3] asserted in the same cycle as db_tick[3] with count=5 → count=0 and ovf[3]=0 next cycle; the tick is not counted.
- EDGE_MODE=2, one press and release → count=2. sel=3 with N_CH=3 → cnt_out=0. reset asserted in WAIT1 → no tick, db_level=0, all outputs 0.

Source files
------------

// File: rtl/debounce_event_counter.sv
// Multi-channel push-button front end: 2-flop synchroniser, counter debouncer, edge detector and
// event counter per channel, plus a registered readout mux. Optional raw-edge counters: DEBOUNCE_RAW_CNT_EN.
module debounce_event_counter #(
  parameter int N_CH          = 4,
  parameter int CNT_W         = 8,
  parameter int STABLE_CYCLES = 1000000,
  parameter int EDGE_MODE     = 0,
  parameter int SATURATE      = 0,
  parameter int SEL_W         = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_CH-1:0]  btn,
  input  logic [N_CH-1:0]  clr,
  input  logic [SEL_W-1:0] sel,
  output logic [CNT_W-1:0] cnt_out,
  output logic [CNT_W-1:0] raw_cnt_out,
  output logic [N_CH-1:0]  db_level,
  output logic [N_CH-1:0]  db_tick,
  output logic [N_CH-1:0]  ovf
);
  localparam int TMR_W = $clog2(STABLE_CYCLES + 1);
  localparam int N_PAD = 1 << SEL_W;
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {STABLE0, WAIT1, STABLE1, WAIT0} db_state_e;

  // Readout table padded to a power of two so any sel value indexes safely; spare slots read 0.
  logic [CNT_W-1:0] count_pad [N_PAD];
  logic [CNT_W-1:0] raw_pad   [N_PAD];
  logic [CNT_W-1:0] cnt_out_q, cnt_out_d;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic             sync1_q, s_q, db_d_q, rise, fall, tick;
      db_state_e        state_q, state_d;
      logic [TMR_W-1:0] timer_q, timer_d;
      logic             level_q, level_d;
      logic [CNT_W-1:0] count_q, count_d;
      logic             ovf_q, ovf_d;

      always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
          STABLE0: if (s_q) begin state_d = WAIT1; timer_d = TMR_ONE; end
          WAIT1: begin
            if (!s_q) begin state_d = STABLE0; timer_d = '0; end
            else if (timer_q == TMR_LAST) begin state_d = STABLE1; timer_d = '0; end
            else timer_d = timer_q + TMR_ONE;
          end
          STABLE1: if (!s_q) begin state_d = WAIT0; timer_d = TMR_ONE; end
          WAIT0: begin
            if (s_q) begin state_d = STABLE1; timer_d = '0; end
            else if (timer_q == TMR_LAST) begin state_d = STABLE0; timer_d = '0; end
            else timer_d = timer_q + TMR_ONE;
          end
          default: begin state_d = STABLE0; timer_d = '0; end
        endcase
        level_d = (state_d == STABLE1) || (state_d == WAIT0);
      end

      assign rise = level_q & ~db_d_q;
      assign fall = ~level_q & db_d_q;

      always_comb begin
        case (EDGE_MODE)
          0:       tick = rise;
          1:       tick = fall;
          default: tick = rise | fall;
        endcase
      end

      // clr outranks a coincident tick, so that tick is dropped.
      always_comb begin
        count_d = count_q;
        ovf_d   = ovf_q;
        if (clr[gi]) begin
          count_d = '0;
          ovf_d   = 1'b0;
        end else if (tick) begin
          if (&count_q) begin
            ovf_d = 1'b1;
            if (SATURATE == 0) count_d = '0;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          sync1_q <= 1'b0;
          s_q     <= 1'b0;
          state_q <= STABLE0;
          timer_q <= '0;
          level_q <= 1'b0;
          db_d_q  <= 1'b0;
          count_q <= '0;
          ovf_q   <= 1'b0;
        end else begin
          sync1_q <= btn[gi];
          s_q     <= sync1_q;
          state_q <= state_d;
          timer_q <= timer_d;
          level_q <= level_d;
          db_d_q  <= level_q;
          count_q <= count_d;
          ovf_q   <= ovf_d;
        end
      end

      assign db_level[gi]  = level_q;
      assign db_tick[gi]   = tick;
      assign ovf[gi]       = ovf_q;
      assign count_pad[gi] = count_q;

`ifdef DEBOUNCE_RAW_CNT_EN
      logic             s_d_q;
      logic [CNT_W-1:0] raw_q, raw_d;

      always_comb begin
        raw_d = raw_q;
        if (clr[gi])            raw_d = '0;
        else if (s_q && !s_d_q) raw_d = raw_q + CNT_W'(1);
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          s_d_q <= 1'b0;
          raw_q <= '0;
        end else begin
          s_d_q <= s_q;
          raw_q <= raw_d;
        end
      end

      assign raw_pad[gi] = raw_q;
`else
      assign raw_pad[gi] = '0;
`endif
    end

    for (gi = N_CH; gi < N_PAD; gi++) begin : g_pad
      assign count_pad[gi] = '0;
      assign raw_pad[gi]   = '0;
    end
  endgenerate

  always_comb cnt_out_d = count_pad[sel];

  always_ff @(posedge clk) begin
    if (reset) cnt_out_q <= '0;
    else       cnt_out_q <= cnt_out_d;
  end

  assign cnt_out = cnt_out_q;

`ifdef DEBOUNCE_RAW_CNT_EN
  logic [CNT_W-1:0] raw_out_q, raw_out_d;

  always_comb raw_out_d = raw_pad[sel];

  always_ff @(posedge clk) begin
    if (reset) raw_out_q <= '0;
    else       raw_out_q <= raw_out_d;
  end

  assign raw_cnt_out = raw_out_q;
`else
  assign raw_cnt_out = '0;
`endif

endmodule

// File: tb/tb_debounce_event_counter.sv
// Bench for debounce_event_counter: a 4-channel rising-edge wrap instance and a 3-channel
// both-edge saturating instance share btn/clr; table vectors plus directed corner sequences.
`timescale 1ns/1ps
module tb_debounce_event_counter;
  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] btn, clr;
  logic [1:0] sel, alt_sel;
  logic [7:0] cnt_out, raw_cnt_out, a_cnt, a_raw;
  logic [3:0] db_level, db_tick, ovf;
  logic [2:0] a_lvl, a_tick, a_ovf;

  int checks = 0;
  int errors = 0;

`ifdef DEBOUNCE_RAW_CNT_EN
  localparam int EXP_RAW0 = 3;
`else
  localparam int EXP_RAW0 = 0;
`endif

  always #5 clk = ~clk;

  debounce_event_counter #(
    .N_CH(4), .CNT_W(8), .STABLE_CYCLES(4), .EDGE_MODE(0), .SATURATE(0)
  ) u_dut (
    .clk(clk), .reset(reset), .btn(btn), .clr(clr), .sel(sel),
    .cnt_out(cnt_out), .raw_cnt_out(raw_cnt_out),
    .db_level(db_level), .db_tick(db_tick), .ovf(ovf)
  );

  debounce_event_counter #(
    .N_CH(3), .CNT_W(8), .STABLE_CYCLES(4), .EDGE_MODE(2), .SATURATE(1)
  ) u_alt (
    .clk(clk), .reset(reset), .btn(btn[2:0]), .clr(clr[2:0]), .sel(alt_sel),
    .cnt_out(a_cnt), .raw_cnt_out(a_raw),
    .db_level(a_lvl), .db_tick(a_tick), .ovf(a_ovf)
  );

  typedef struct {
    logic [3:0] btn;
    logic [7:0] exp_cnt;
    logic [3:0] exp_lvl;
    logic [3:0] exp_tick;
    logic [7:0] exp_alt_cnt;
    logic [2:0] exp_alt_tick;
  } vec_t;

  vec_t vecs [28];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic press(input int ch);
    btn[ch] = 1'b1;
    repeat (8) step();
    btn[ch] = 1'b0;
    repeat (8) step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks;
    int first;
    bit found;
    logic pat;

    // Clean press on btn[2] held 20 cycles then released: tick 6 edges after the step,
    // cnt_out 2 edges after the tick; the both-edge instance also ticks on the release.
    for (int i = 0; i < 28; i++) begin
      vecs[i].btn          = (i < 20) ? 4'b0100 : 4'b0000;
      vecs[i].exp_cnt      = (i >= 7) ? 8'd1 : 8'd0;
      vecs[i].exp_lvl      = (i >= 5 && i < 25) ? 4'b0100 : 4'b0000;
      vecs[i].exp_tick     = (i == 5) ? 4'b0100 : 4'b0000;
      vecs[i].exp_alt_cnt  = (i >= 27) ? 8'd2 : ((i >= 7) ? 8'd1 : 8'd0);
      vecs[i].exp_alt_tick = (i == 5 || i == 25) ? 3'b100 : 3'b000;
    end

    reset = 1'b1; btn = '0; clr = '0; sel = 2'd2; alt_sel = 2'd2;
    repeat (3) step();
    chk("rst_cnt_out", 32'(cnt_out), 32'd0);
    chk("rst_raw_cnt_out", 32'(raw_cnt_out), 32'd0);
    chk("rst_db_level", 32'(db_level), 32'd0);
    chk("rst_db_tick", 32'(db_tick), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_alt_cnt", 32'(a_cnt), 32'd0);
    $display("reset: cnt=%0d lvl=%b tick=%b ovf=%b", cnt_out, db_level, db_tick, ovf);
    reset = 1'b0;

    for (int i = 0; i < 28; i++) begin
      btn = vecs[i].btn;
      step();
      chk($sformatf("vec%0d_cnt", i), 32'(cnt_out), 32'(vecs[i].exp_cnt));
      chk($sformatf("vec%0d_lvl", i), 32'(db_level), 32'(vecs[i].exp_lvl));
      chk($sformatf("vec%0d_tick", i), 32'(db_tick), 32'(vecs[i].exp_tick));
      chk($sformatf("vec%0d_ovf", i), 32'(ovf), 32'd0);
      chk($sformatf("vec%0d_alt_cnt", i), 32'(a_cnt), 32'(vecs[i].exp_alt_cnt));
      chk($sformatf("vec%0d_alt_tick", i), 32'(a_tick), 32'(vecs[i].exp_alt_tick));
      $display("vec %0d: btn=%b cnt=%0d lvl=%b tick=%b alt_cnt=%0d alt_tick=%b",
               i, btn, cnt_out, db_level, db_tick, a_cnt, a_tick);
    end

    // Bounce on btn[0]: 1,0,1,0 for two cycles each, then steady high.
    sel = 2'd0;
    ticks = 0;
    for (int i = 0; i < 20; i++) begin
      pat = (i < 8) ? ((i % 4) < 2) : 1'b1;
      btn[0] = pat;
      step();
      if (db_tick[0]) ticks++;
    end
    repeat (2) step();
    chk("bounce_ticks", 32'(ticks), 32'd1);
    chk("bounce_cnt", 32'(cnt_out), 32'd1);
    chk("bounce_raw", 32'(raw_cnt_out), 32'(EXP_RAW0));
    $display("bounce: ticks=%0d cnt=%0d raw=%0d", ticks, cnt_out, raw_cnt_out);
    btn[0] = 1'b0;
    repeat (10) step();

    // Channel 1: 255 presses fill the counter, the 256th wraps (main) or saturates (alt).
    sel = 2'd1; alt_sel = 2'd1;
    repeat (255) press(1);
    repeat (2) step();
    chk("ovf_255_cnt", 32'(cnt_out), 32'd255);
    chk("ovf_255_flag", 32'(ovf[1]), 32'd0);
    chk("sat_alt_cnt", 32'(a_cnt), 32'd255);
    chk("sat_alt_flag", 32'(a_ovf[1]), 32'd1);
    $display("255 presses: cnt=%0d ovf=%b alt_cnt=%0d alt_ovf=%b", cnt_out, ovf, a_cnt, a_ovf);
    press(1);
    repeat (2) step();
    chk("wrap_cnt", 32'(cnt_out), 32'd0);
    chk("wrap_flag", 32'(ovf[1]), 32'd1);
    chk("sat_hold_cnt", 32'(a_cnt), 32'd255);
    chk("sat_hold_flag", 32'(a_ovf[1]), 32'd1);
    $display("256th press: cnt=%0d ovf=%b alt_cnt=%0d alt_ovf=%b", cnt_out, ovf, a_cnt, a_ovf);

    clr = 4'b0010;
    step();
    clr = '0;
    chk("clr1_ovf", 32'(ovf[1]), 32'd0);
    chk("clr1_alt_ovf", 32'(a_ovf[1]), 32'd0);
    step();
    chk("clr1_cnt", 32'(cnt_out), 32'd0);
    chk("clr1_alt_cnt", 32'(a_cnt), 32'd0);
    $display("clr ch1: cnt=%0d ovf=%b alt_cnt=%0d", cnt_out, ovf, a_cnt);

    // Channel 3: count to 5, then clr coincident with the next tick must win.
    sel = 2'd3;
    repeat (5) press(3);
    repeat (2) step();
    chk("ch3_cnt5", 32'(cnt_out), 32'd5);
    btn[3] = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      step();
      if (db_tick[3]) found = 1'b1;
    end
    chk("ch3_tick_seen", 32'(found), 32'd1);
    clr = 4'b1000;
    step();
    clr = '0;
    chk("clr_tick_ovf", 32'(ovf[3]), 32'd0);
    step();
    chk("clr_tick_cnt", 32'(cnt_out), 32'd0);
    btn[3] = 1'b0;
    repeat (10) step();
    chk("clr_tick_cnt_after", 32'(cnt_out), 32'd0);
    $display("clr vs tick ch3: cnt=%0d ovf=%b", cnt_out, ovf);

    // Select latency and out-of-range select on the 3-channel instance.
    sel = 2'd2; alt_sel = 2'd2;
    step();
    chk("sel2_cnt", 32'(cnt_out), 32'd1);
    chk("alt_sel2_cnt", 32'(a_cnt), 32'd2);
    alt_sel = 2'd3;
    step();
    chk("alt_sel3_cnt", 32'(a_cnt), 32'd0);
    $display("select: cnt=%0d alt_sel3_cnt=%0d", cnt_out, a_cnt);

    // Reset in WAIT1 abandons the pending rise.
    btn[2] = 1'b1;
    repeat (4) step();
    reset = 1'b1;
    btn[2] = 1'b0;
    step();
    chk("rstw_cnt", 32'(cnt_out), 32'd0);
    chk("rstw_raw", 32'(raw_cnt_out), 32'd0);
    chk("rstw_lvl", 32'(db_level), 32'd0);
    chk("rstw_tick", 32'(db_tick), 32'd0);
    chk("rstw_ovf", 32'(ovf), 32'd0);
    chk("rstw_alt_lvl", 32'(a_lvl), 32'd0);
    reset = 1'b0;
    ticks = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (db_tick != 4'b0000) ticks++;
    end
    chk("rstw_no_tick", 32'(ticks), 32'd0);
    chk("rstw_lvl_after", 32'(db_level), 32'd0);
    chk("rstw_cnt_after", 32'(cnt_out), 32'd0);
    $display("reset in WAIT1: ticks=%0d lvl=%b cnt=%0d", ticks, db_level, cnt_out);

    // Button held through reset is counted as a rise 6 cycles after release of reset.
    sel = 2'd0;
    reset = 1'b1;
    btn[0] = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    first = 0;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (db_tick[0] && first == 0) first = k;
    end
    chk("held_tick_latency", 32'(first), 32'd6);
    chk("held_cnt", 32'(cnt_out), 32'd1);
    $display("held through reset: tick at %0d cnt=%0d", first, cnt_out);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
